sbox_share_ctrl: RTL

Time-shares a small bank of byte S-box lanes between two requesters: the round datapath (SubBytes over a 128-bit state) and the key expansion (SubWord over a 32-bit word). A non-preemptive arbiter grants one job at a time. Each granted job runs through the lanes in beats of `LANES` bytes per cycle. The result is returned with a one-cycle valid pulse. The block sits between the round controller and the key scheduler, so one set of substitution tables serves both.

---
 rtl/sbox_share_pkg.sv | 28 ++
 rtl/sbox.sv | 45 ++++
 rtl/sbox_share_lane_array.sv | 17 +
 rtl/sbox_share_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/sbox_share_pkg.sv
// Shared definitions for the S-box time-sharing controller: FSM states,
// grant encoding and beat-count helpers derived from the lane count.
package sbox_share_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN_STATE = 2'd1,
    RUN_WORD  = 2'd2
  } ctrlState_t;

  localparam logic GRANT_STATE = 1'b0;
  localparam logic GRANT_WORD  = 1'b1;

  localparam int STATE_BYTES = 16;
  localparam int WORD_BYTES  = 4;
  localparam int BEAT_W      = 4;

  // Number of beats a state job takes with the given lane count.
  function automatic int stateBeats(input int lanes);
    return STATE_BYTES / lanes;
  endfunction

  // Number of beats a word job takes with the given lane count.
  function automatic int wordBeats(input int lanes);
    return WORD_BYTES / lanes;
  endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box for one byte: multiplicative inverse in GF(2^8)
// (computed as x^254) followed by the AES affine transform.
module sbox (
  input  logic [7:0] byteIn,
  output logic [7:0] byteOut
);

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 through an addition chain; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gfInv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gfMul(x, x);
    x3   = gfMul(x2, x);
    x6   = gfMul(x3, x3);
    x12  = gfMul(x6, x6);
    x15  = gfMul(x12, x3);
    x30  = gfMul(x15, x15);
    x60  = gfMul(x30, x30);
    x120 = gfMul(x60, x60);
    x240 = gfMul(x120, x120);
    x252 = gfMul(x240, x12);
    return gfMul(x252, x2);
  endfunction

  logic [7:0] inv;

  // Inverse then affine transform.
  always_comb begin
    inv     = gfInv(byteIn);
    byteOut = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/sbox_share_lane_array.sv
// LANES parallel S-box instances. Lane k handles the k-th byte counted
// from the MSB end of the bus, matching the buffer byte ordering.
module sbox_lane_array #(
  parameter int LANES = 4
) (
  input  logic [8*LANES-1:0] laneIn,
  output logic [8*LANES-1:0] laneOut
);

  for (genvar k = 0; k < LANES; k++) begin : gLane
    sbox uSbox (
      .byteIn (laneIn [8*LANES-1-8*k -: 8]),
      .byteOut(laneOut[8*LANES-1-8*k -: 8])
    );
  end

endmodule

// File: rtl/sbox_share_ctrl.sv
// Time-shares LANES S-box lanes between SubBytes (128-bit state) and
// SubWord (32-bit word) requests. Non-preemptive arbiter, one job at a time,
// LANES bytes per beat, one-cycle result pulse per job.
// Build option: define SBOX_SHARE_FIXED_PRIO_EN to give the word request
// fixed priority on a tie instead of round-robin.
module sbox_share_ctrl
  import sbox_share_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stateInValid,
  input  logic [127:0] stateIn,
  output logic         stateInReady,
  input  logic         wordInValid,
  input  logic [31:0]  wordIn,
  output logic         wordInReady,
  output logic         stateOutValid,
  output logic [127:0] stateOut,
  output logic         wordOutValid,
  output logic [31:0]  wordOut
);

  localparam int LANE_W = 8 * LANES;
  localparam logic [BEAT_W-1:0] STATE_LAST = BEAT_W'(stateBeats(LANES) - 1);
  localparam logic [BEAT_W-1:0] WORD_LAST  = BEAT_W'(wordBeats(LANES) - 1);

  ctrlState_t          curState, nextState;
  logic [BEAT_W-1:0]   beat;
  logic [127:0]        jobBuf;
  logic [127:0]        resReg;
  logic [127:0]        resNext;
  logic [LANE_W-1:0]   laneIn, laneOut;
  logic                grantState, grantWord;
  logic                stateAccept, wordAccept;
  logic                lastBeat;

`ifndef SBOX_SHARE_FIXED_PRIO_EN
  logic lastGrant;
`endif

  // Arbitration: a lone requester wins; a tie is settled by priority mode.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grantState = 1'b0;
    grantWord  = 1'b0;
    if (stateInValid && wordInValid) begin
`ifdef SBOX_SHARE_FIXED_PRIO_EN
      grantWord = 1'b1;
`else
      if (lastGrant == GRANT_WORD) grantState = 1'b1;
      else                         grantWord  = 1'b1;
`endif
    end else begin
      grantState = stateInValid;
      grantWord  = wordInValid;
    end
  end

  assign stateInReady = (curState == IDLE) && grantState;
  assign wordInReady  = (curState == IDLE) && grantWord;
  assign stateAccept  = stateInValid && stateInReady;
  assign wordAccept   = wordInValid && wordInReady;

  assign lastBeat = ((curState == RUN_STATE) && (beat == STATE_LAST))
                 || ((curState == RUN_WORD)  && (beat == WORD_LAST));

  // Word jobs sit in the top 32 bits so both job types share one indexing.
  assign laneIn = jobBuf[127 - LANE_W*int'(beat) -: LANE_W];

  sbox_lane_array #(.LANES(LANES)) uLanes (
    .laneIn (laneIn),
    .laneOut(laneOut)
  );

  // Result register with the current beat's lane outputs merged in.
  always_comb begin
    resNext = resReg;
    resNext[127 - LANE_W*int'(beat) -: LANE_W] = laneOut;
  end

  // Next-state logic.
  always_comb begin
    nextState = curState;
    unique case (curState)
      IDLE: begin
        if (stateAccept)     nextState = RUN_STATE;
        else if (wordAccept) nextState = RUN_WORD;
      end
      RUN_STATE, RUN_WORD: begin
        if (lastBeat) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) curState <= IDLE;
    else        curState <= nextState;
  end

`ifndef SBOX_SHARE_FIXED_PRIO_EN
  // Remember who the most recent accepted job served.
  always_ff @(posedge clk) begin
    if (!rst_n)          lastGrant <= GRANT_WORD;
    else if (stateAccept) lastGrant <= GRANT_STATE;
    else if (wordAccept)  lastGrant <= GRANT_WORD;
  end
`endif

  // Job buffer and scratch result: pure datapath, always written before read.
  // NOTE: these wide data registers are deliberately not reset; only control and visible outputs are.
  always_ff @(posedge clk) begin
    if (stateAccept)     jobBuf <= stateIn;
    else if (wordAccept) jobBuf <= {wordIn, 96'h0};
    if (curState != IDLE) resReg <= resNext;
  end

  // Beat counter, published outputs and one-cycle completion pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat          <= '0;
      stateOutValid <= 1'b0;
      wordOutValid  <= 1'b0;
      stateOut      <= '0;
      wordOut       <= '0;
    end else begin
      stateOutValid <= (curState == RUN_STATE) && lastBeat;
      wordOutValid  <= (curState == RUN_WORD) && lastBeat;
      if (stateAccept || wordAccept || lastBeat) beat <= '0;
      else if (curState != IDLE)                 beat <= beat + 1'b1;
      if ((curState == RUN_STATE) && lastBeat) stateOut <= resNext;
      if ((curState == RUN_WORD) && lastBeat)  wordOut  <= resNext[127:96];
    end
  end

endmodule
